// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one synchronous-read memory port between instruction fetch
//            and load/store, with data priority and a fetch-starvation limit.
// Revision : 1.0
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W          = 32,
    parameter int MAX_DATA_STREAK = 4,
    parameter int STREAK_W        = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [2:0] {
        R_NONE   = 3'd0,
        R_IF     = 3'd1,
        R_DLOAD  = 3'd2,
        R_DSTORE = 3'd3,
        R_DERR   = 3'd4
    } resp_t;

    localparam logic [STREAK_W-1:0] c_max_streak = STREAK_W'(MAX_DATA_STREAK);

    resp_t               r_resp_state;
    resp_t               w_resp_next;
    logic [STREAK_W-1:0] r_streak;
    logic [STREAK_W-1:0] w_streak_next;
    logic                w_if_win;
    logic                w_d_win;
    logic                w_d_misaligned;

    assign w_d_misaligned = (d_addr[1:0] != 2'b00);

    // Data wins contention until it has won MAX_DATA_STREAK times in a row.
    always_comb begin
        w_if_win = 1'b0;
        w_d_win  = 1'b0;
        if (!rst) begin
            if (d_req && (!if_req || (r_streak != c_max_streak))) begin
                w_d_win = 1'b1;
            end else if (if_req) begin
                w_if_win = 1'b1;
            end
        end
    end

    assign if_gnt = w_if_win;
    assign d_gnt  = w_d_win;

    always_comb begin
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        w_resp_next = R_NONE;
        if (w_if_win) begin
            mem_addr    = if_addr;
            mem_read    = 1'b1;
            w_resp_next = R_IF;
        end else if (w_d_win) begin
            if (w_d_misaligned) begin
                w_resp_next = R_DERR;
            end else if (d_we) begin
                mem_addr    = d_addr;
                mem_wdata   = d_wdata;
                mem_write   = 1'b1;
                w_resp_next = R_DSTORE;
            end else begin
                mem_addr    = d_addr;
                mem_read    = 1'b1;
                w_resp_next = R_DLOAD;
            end
        end
    end

    always_comb begin
        w_streak_next = r_streak;
        if (!if_req || w_if_win) begin
            w_streak_next = '0;
        end else if (w_d_win && (r_streak != c_max_streak)) begin
            w_streak_next = r_streak + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_resp_state <= R_NONE;
            r_streak     <= '0;
        end else begin
            r_resp_state <= w_resp_next;
            r_streak     <= w_streak_next;
        end
    end

    // Gated by rst so a grant made just before reset never shows a response.
    always_comb begin
        if_rvalid = 1'b0;
        if_rdata  = '0;
        d_rvalid  = 1'b0;
        d_rdata   = '0;
        d_err     = 1'b0;
        if (!rst) begin
            case (r_resp_state)
                R_IF: begin
                    if_rvalid = 1'b1;
                    if_rdata  = mem_rdata;
                end
                R_DLOAD: begin
                    d_rvalid = 1'b1;
                    d_rdata  = mem_rdata;
                end
                R_DSTORE: begin
                    d_rvalid = 1'b1;
                end
                R_DERR: begin
                    d_rvalid = 1'b1;
                    d_err    = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
